boss_hp_tracker: RTL and testbench

- Owns the boss hit-point counter and drives the `bosshp` bus consumed by the boss movement block.
- Each cycle it checks the player shot against the boss hitbox (from `bossx`/`bossy`) and applies damage.
- It enforces post-hit invulnerability, reports the fight phase, and latches boss death.
- It closes the loop: the movement block reads HP and drives position; this block reads position and drives HP.

---
 rtl/boss_hp_tracker.sv | 121 ++++++++++++
 tb/tb_boss_hp_tracker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/boss_hp_tracker.sv
// Boss hit-point tracker: shot/hitbox collision, damage with invulnerability
// cooldowns, fight phase decode and sticky death flag.
module boss_hp_tracker #(
    parameter int HP_MAX     = 450,
    parameter int DAMAGE     = 10,
    parameter int PH2_TH     = 300,
    parameter int PH3_TH     = 150,
    parameter int BOSS_W     = 64,
    parameter int BOSS_H     = 48,
    parameter int HIT_COOL   = 8,
    parameter int PHASE_COOL = 32
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       boss,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic       shot_valid,
    input  logic [9:0] shotx,
    input  logic [9:0] shoty,
    output logic [9:0] bosshp,
    output logic       hit,
    output logic       shot_kill,
    output logic [1:0] boss_phase,
    output logic       boss_dead
);

    localparam int CW = (PHASE_COOL > HIT_COOL) ? $clog2(PHASE_COOL) : $clog2(HIT_COOL);

    typedef enum logic [1:0] {WAIT, FIGHT, COOL, DEAD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0]    hp_n, hp_dmg;
    logic          hit_n, kill_n, dead_n;
    logic [10:0]   box_r, box_b;
    logic          coll, crossed;

    // Right/bottom edges in 11 bits so a boss near x=1023 does not wrap.
    assign box_r = {1'b0, bossx} + 11'(BOSS_W);
    assign box_b = {1'b0, bossy} + 11'(BOSS_H);
    assign coll  = shot_valid
                   && (shotx >= bossx) && ({1'b0, shotx} < box_r)
                   && (shoty >= bossy) && ({1'b0, shoty} < box_b);

    assign hp_dmg  = (bosshp > 10'(DAMAGE)) ? bosshp - 10'(DAMAGE) : '0;
    assign crossed = ((bosshp > 10'(PH2_TH)) && (hp_dmg <= 10'(PH2_TH)))
                  || ((bosshp > 10'(PH3_TH)) && (hp_dmg <= 10'(PH3_TH)));

    always_ff @(posedge clk22 or negedge rst) begin
        if (!rst) begin
            state     <= WAIT;
            cnt       <= '0;
            bosshp    <= 10'(HP_MAX);
            hit       <= 1'b0;
            shot_kill <= 1'b0;
            boss_dead <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bosshp    <= hp_n;
            hit       <= hit_n;
            shot_kill <= kill_n;
            boss_dead <= dead_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hp_n    = bosshp;
        hit_n   = 1'b0;
        kill_n  = 1'b0;
        dead_n  = boss_dead;
        unique case (state)
            WAIT: begin
                if (boss) state_n = FIGHT;
            end
            FIGHT: begin
                if (!boss) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end else if (coll) begin
                    hp_n   = hp_dmg;
                    hit_n  = 1'b1;
                    kill_n = 1'b1;
                    if (hp_dmg == '0) begin
                        state_n = DEAD;
                        dead_n  = 1'b1;
                    end else begin
                        state_n = COOL;
                        cnt_n   = crossed ? CW'(PHASE_COOL - 1) : CW'(HIT_COOL - 1);
                    end
                end
            end
            COOL: begin
                if (!boss) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end else begin
                    kill_n = coll;
                    if (cnt == '0) state_n = FIGHT;
                    else           cnt_n   = cnt - 1'b1;
                end
            end
            DEAD: begin
                hp_n   = '0;
                dead_n = 1'b1;
            end
            default: state_n = WAIT;
        endcase
    end

    always_comb begin
        if (bosshp == '0)                boss_phase = 2'd0;
        else if (bosshp <= 10'(PH3_TH))  boss_phase = 2'd3;
        else if (bosshp <= 10'(PH2_TH))  boss_phase = 2'd2;
        else                             boss_phase = 2'd1;
    end

endmodule

// File: tb/tb_boss_hp_tracker.sv
// Directed bench for boss_hp_tracker; a second instance with a small HP_MAX
// exercises damage saturation at zero.
module tb_boss_hp_tracker;

    logic       clk22 = 1'b0;
    logic       rst = 1'b0;
    logic       boss = 1'b0;
    logic [9:0] bossx = 10'd100;
    logic [9:0] bossy = 10'd75;
    logic       shot_valid = 1'b0;
    logic [9:0] shotx = '0;
    logic [9:0] shoty = '0;

    logic [9:0] bosshp, sat_hp;
    logic       hit, shot_kill, boss_dead, sat_hit, sat_kill, sat_dead;
    logic [1:0] boss_phase, sat_phase;

    int checks = 0;
    int failures = 0;

    always #5 clk22 = ~clk22;

    boss_hp_tracker u_dut (
        .clk22(clk22), .rst(rst), .boss(boss), .bossx(bossx), .bossy(bossy),
        .shot_valid(shot_valid), .shotx(shotx), .shoty(shoty),
        .bosshp(bosshp), .hit(hit), .shot_kill(shot_kill),
        .boss_phase(boss_phase), .boss_dead(boss_dead)
    );

    boss_hp_tracker #(.HP_MAX(15)) u_sat (
        .clk22(clk22), .rst(rst), .boss(boss), .bossx(bossx), .bossy(bossy),
        .shot_valid(shot_valid), .shotx(shotx), .shoty(shoty),
        .bosshp(sat_hp), .hit(sat_hit), .shot_kill(sat_kill),
        .boss_phase(sat_phase), .boss_dead(sat_dead)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_phase(input int hp);
        if (hp == 0)        return 0;
        else if (hp <= 150) return 3;
        else if (hp <= 300) return 2;
        else                return 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk22);
    endtask

    // Presents a shot for exactly one rising edge; returns at the following negedge.
    task automatic shoot(input int x, input int y);
        shot_valid = 1'b1;
        shotx = 10'(x);
        shoty = 10'(y);
        @(negedge clk22);
        shot_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int hp, input int h, input int k);
        check_eq({tag, "_hp"}, int'(bosshp), hp);
        check_eq({tag, "_hit"}, int'(hit), h);
        check_eq({tag, "_kill"}, int'(shot_kill), k);
    endtask

    task automatic hit_after(input int gap, input int hp);
        tick(gap);
        shoot(120, 90);
        expect_out("hit", hp, 1, 1);
        check_eq("hit_phase", int'(boss_phase), exp_phase(hp));
    endtask

    initial begin
        // Reset held with clocks running
        tick(3);
        expect_out("rst", 450, 0, 0);
        check_eq("rst_dead", int'(boss_dead), 0);
        check_eq("rst_phase", int'(boss_phase), 1);
        rst = 1'b1;
        boss = 1'b1;
        tick(1);

        // Basic hit and the 8-cycle cooldown
        shoot(120, 90);
        expect_out("basic", 440, 1, 1);
        check_eq("sat_hp1", int'(sat_hp), 5);
        check_eq("sat_phase1", int'(sat_phase), 3);
        tick(1);
        expect_out("pulse_end", 440, 0, 0);
        tick(1);
        shoot(120, 90);
        expect_out("cool_absorb", 440, 0, 1);
        tick(4);
        shoot(120, 90);
        expect_out("cool_last", 440, 0, 1);
        shoot(120, 90);
        expect_out("second", 430, 1, 1);
        check_eq("sat_hp2", int'(sat_hp), 0);
        check_eq("sat_dead", int'(sat_dead), 1);
        check_eq("sat_phase2", int'(sat_phase), 0);

        // Hitbox edges
        tick(8);
        shoot(163, 122);
        expect_out("edge_in", 420, 1, 1);
        tick(8);
        shoot(164, 90);
        expect_out("edge_right", 420, 0, 0);
        shoot(99, 90);
        expect_out("edge_left", 420, 0, 0);
        shoot(120, 123);
        expect_out("edge_bottom", 420, 0, 0);
        shoot(120, 74);
        expect_out("edge_top", 420, 0, 0);
        bossx = 10'd1000;
        shoot(1020, 90);
        expect_out("no_wrap", 410, 1, 1);
        bossx = 10'd100;

        // Boss drop during cooldown, then immediate damage on return
        tick(2);
        boss = 1'b0;
        shoot(120, 90);
        expect_out("drop", 410, 0, 0);
        boss = 1'b1;
        tick(1);
        shoot(120, 90);
        expect_out("return", 400, 1, 1);

        for (int e = 390; e >= 310; e -= 10) hit_after(8, e);
        hit_after(8, 300);

        // Continuous shots through the 32-cycle phase cooldown
        shot_valid = 1'b1;
        shotx = 10'd120;
        shoty = 10'd90;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk22);
            expect_out("phase_cool", 300, 0, 1);
        end
        @(negedge clk22);
        shot_valid = 1'b0;
        expect_out("phase_exit", 290, 1, 1);

        for (int e = 280; e >= 150; e -= 10) hit_after(8, e);
        hit_after(32, 140);
        for (int e = 130; e >= 0; e -= 10) hit_after(8, e);
        check_eq("dead_flag", int'(boss_dead), 1);

        // Shots pass through a dead boss
        tick(3);
        shoot(120, 90);
        expect_out("dead_shot", 0, 0, 0);
        tick(5);
        check_eq("dead_hold", int'(boss_dead), 1);
        check_eq("dead_phase", int'(boss_phase), 0);

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1;
        expect_out("async_rst", 450, 0, 0);
        check_eq("async_dead", int'(boss_dead), 0);
        check_eq("async_phase", int'(boss_phase), 1);
        check_eq("async_sat", int'(sat_hp), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
